// File: rtl/cpu_clock_gen.sv
// cpu_clock_gen
//   Divides the 48 MHz FPGA oscillator clock down to the free-running CPU
//   clock. The output has a 50% duty cycle and a period of 2*HALF_PERIOD
//   fpga_clk cycles. The block also provides rise/fall strobes, a run/stop gate
//   that can only stop the clock while it is low, and a counter of completed
//   CPU cycles.
//   Optional feature macro: CLKGEN_STEP_EN. When it is defined, the block gains
//   a `step` input. A rising edge on `step` while stopped produces exactly one
//   full CPU cycle.
module cpu_clock_gen #(
   parameter int HALF_PERIOD = 24
) (
   input  logic        fpga_clk,
   input  logic        rst,
   input  logic        en,
`ifdef CLKGEN_STEP_EN
   input  logic        step,
`endif
   output logic        clk_out,
   output logic        rise_stb,
   output logic        fall_stb,
   output logic        running,
   output logic [15:0] cycle_count
);

   // The clamp only keeps the widths legal while the $error below reports the bad value
   localparam int CNT_W = (HALF_PERIOD < 2) ? 1 : $clog2(HALF_PERIOD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   if (HALF_PERIOD < 2) begin : g_bad_half_period
      $error("cpu_clock_gen: HALF_PERIOD must be >= 2 (got %0d)", HALF_PERIOD);
   end

   typedef enum logic [0:0] {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             clk_out_r, clk_out_s;
   logic             rise_stb_r, rise_stb_s;
   logic             fall_stb_r, fall_stb_s;
   logic [15:0]      cycle_count_r, cycle_count_s;
   // Grants one rise at the next low->high decision even when en is low
   logic             one_shot_r, one_shot_s;
   logic             step_edge_s;

`ifdef CLKGEN_STEP_EN
   logic             step_d_r;

   // Delay step by one cycle so that a 0->1 transition can be detected
   always_ff @(posedge fpga_clk) begin
      if (!rst) begin
         step_d_r <= 1'b0;
      end else begin
         step_d_r <= step;
      end
   end

   assign step_edge_s = step & ~step_d_r;
`else
   assign step_edge_s = 1'b0;
`endif

   // Next-state logic: the phase counter, the run/stop decision and the strobes
   always_comb begin
      state_s       = state_r;
      cnt_s         = cnt_r;
      clk_out_s     = clk_out_r;
      rise_stb_s    = 1'b0;
      fall_stb_s    = 1'b0;
      cycle_count_s = cycle_count_r;
      one_shot_s    = one_shot_r;
      case (state_r)
         ST_STOP: begin
            clk_out_s = 1'b0;
            cnt_s     = '0;
            if (en) begin
               // If en and a step edge arrive together, run continuously
               state_s    = ST_RUN;
               one_shot_s = 1'b0;
            end else if (step_edge_s) begin
               state_s    = ST_RUN;
               one_shot_s = 1'b1;
            end else begin
               state_s    = ST_STOP;
            end
         end
         ST_RUN: begin
            if (cnt_r != CNT_LAST) begin
               cnt_s = cnt_r + CNT_ONE;
            end else begin
               cnt_s = '0;
               if (clk_out_r) begin
                  // A high phase always finishes, so no runt pulse is produced
                  clk_out_s     = 1'b0;
                  fall_stb_s    = 1'b1;
                  cycle_count_s = cycle_count_r + 16'd1;
               end else if (en || one_shot_r) begin
                  clk_out_s  = 1'b1;
                  rise_stb_s = 1'b1;
                  one_shot_s = 1'b0;
               end else begin
                  // The clock can only stop at the end of a full low phase
                  state_s = ST_STOP;
               end
            end
         end
         default: begin
            state_s    = ST_STOP;
            cnt_s      = '0;
            clk_out_s  = 1'b0;
            one_shot_s = 1'b0;
         end
      endcase
   end

   // State and output registers; the synchronous reset overrides everything
   always_ff @(posedge fpga_clk) begin
      if (!rst) begin
         state_r       <= ST_STOP;
         cnt_r         <= '0;
         clk_out_r     <= 1'b0;
         rise_stb_r    <= 1'b0;
         fall_stb_r    <= 1'b0;
         cycle_count_r <= 16'd0;
         one_shot_r    <= 1'b0;
      end else begin
         state_r       <= state_s;
         cnt_r         <= cnt_s;
         clk_out_r     <= clk_out_s;
         rise_stb_r    <= rise_stb_s;
         fall_stb_r    <= fall_stb_s;
         cycle_count_r <= cycle_count_s;
         one_shot_r    <= one_shot_s;
      end
   end

   assign clk_out     = clk_out_r;
   assign rise_stb    = rise_stb_r;
   assign fall_stb    = fall_stb_r;
   assign running     = (state_r == ST_RUN);
   assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_cpu_clock_gen.sv
// tb_cpu_clock_gen
//   Self-checking bench for cpu_clock_gen with HALF_PERIOD = 24.
//   Expected rise/fall strobes are queued, each with its cycle number and the
//   cycle_count value expected at a fall, whenever stimulus that should cause
//   them is driven. The queue entries are compared as the DUT produces strobes.
//   Level checks on clk_out/running come from a small table and from a few
//   hand-written sequences.
module tb_cpu_clock_gen;

   localparam int HP = 24;

   logic        fpga_clk = 1'b0;
   logic        rst      = 1'b0;
   logic        en       = 1'b0;
`ifdef CLKGEN_STEP_EN
   logic        step     = 1'b0;
`endif
   logic        clk_out;
   logic        rise_stb;
   logic        fall_stb;
   logic        running;
   logic [15:0] cycle_count;

   cpu_clock_gen #(.HALF_PERIOD(HP)) dut (
      .fpga_clk    (fpga_clk),
      .rst         (rst),
      .en          (en),
`ifdef CLKGEN_STEP_EN
      .step        (step),
`endif
      .clk_out     (clk_out),
      .rise_stb    (rise_stb),
      .fall_stb    (fall_stb),
      .running     (running),
      .cycle_count (cycle_count)
   );

   always #5 fpga_clk = ~fpga_clk;

   typedef struct {
      bit          is_rise;
      int          cyc;
      logic [15:0] count;
   } ev_t;

   typedef struct {
      int  cyc_rel;
      bit  clk_exp;
      bit  run_exp;
   } vec_t;

   ev_t  sb_q[$];
   vec_t vecs[7];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input bit is_rise, input int at, input logic [15:0] count);
      ev_t e;
      e.is_rise = is_rise;
      e.cyc     = at;
      e.count   = count;
      sb_q.push_back(e);
   endtask

   // n full CPU cycles for en (or step) first seen at the edge after cycle `origin`
   task automatic push_cycles(input int origin, input int n, input logic [15:0] count0);
      for (int k = 0; k < n; k++) begin
         push_ev(1'b1, origin + 1 + HP + 2 * HP * k, 16'd0);
         push_ev(1'b0, origin + 1 + 2 * HP + 2 * HP * k, 16'(count0 + 16'(k + 1)));
      end
   endtask

   // Advance one fpga_clk cycle, sample on the falling edge, then score any strobes
   task automatic tick();
      ev_t e;
      @(negedge fpga_clk);
      cyc++;
      if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
         check("missed_strobe", 32'(cyc), 32'(sb_q[0].cyc));
         sb_q.delete(0);
      end
      if (rise_stb || fall_stb) begin
         if (sb_q.size() == 0) begin
            check("unexpected_strobe", {30'd0, rise_stb, fall_stb}, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("strobe_rise", {31'd0, rise_stb}, {31'd0, e.is_rise});
            check("strobe_fall", {31'd0, fall_stb}, {31'd0, !e.is_rise});
            check("strobe_cycle", 32'(cyc), 32'(e.cyc));
            check("clk_at_strobe", {31'd0, clk_out}, {31'd0, e.is_rise});
            if (!e.is_rise) begin
               check("count_at_fall", {16'd0, cycle_count}, {16'd0, e.count});
            end
         end
      end
   endtask

   task automatic run_until(input int target);
      while (cyc < target) begin
         tick();
      end
   endtask

   initial begin
      int origin;
      int o2;
      int o3;

      vecs[0] = '{1,       1'b0, 1'b1};
      vecs[1] = '{HP,      1'b0, 1'b1};
      vecs[2] = '{HP + 1,  1'b1, 1'b1};
      vecs[3] = '{2 * HP,  1'b1, 1'b1};
      vecs[4] = '{2*HP+1,  1'b0, 1'b1};
      vecs[5] = '{3 * HP,  1'b0, 1'b1};
      vecs[6] = '{3*HP+1,  1'b1, 1'b1};

      // Reset state
      rst = 1'b0;
      en  = 1'b0;
      repeat (3) tick();
      check("rst_clk_out", {31'd0, clk_out}, 32'd0);
      check("rst_running", {31'd0, running}, 32'd0);
      check("rst_count", {16'd0, cycle_count}, 32'd0);
      check("rst_strobes", {30'd0, rise_stb, fall_stb}, 32'd0);
      rst = 1'b1;
      repeat (2) tick();
      check("idle_running", {31'd0, running}, 32'd0);

      // Start-up timing from the table, then 1000 continuous CPU cycles
      origin = cyc;
      en     = 1'b1;
      push_cycles(origin, 1000, 16'd0);
      foreach (vecs[i]) begin
         run_until(origin + vecs[i].cyc_rel);
         check($sformatf("vec%0d_clk_out", i), {31'd0, clk_out}, {31'd0, vecs[i].clk_exp});
         check($sformatf("vec%0d_running", i), {31'd0, running}, {31'd0, vecs[i].run_exp});
      end
      run_until(origin + 1 + 2 * HP * 1000);
      check("count_1000", {16'd0, cycle_count}, 32'd1000);
      en = 1'b0;
      run_until(origin + 1 + 2 * HP * 1000 + HP);
      check("stop_after_1000_running", {31'd0, running}, 32'd0);
      check("stop_after_1000_clk", {31'd0, clk_out}, 32'd0);

      // en dropped during the high phase: full high, full low, then stop
      origin = cyc;
      en     = 1'b1;
      push_ev(1'b1, origin + 25, 16'd0);
      push_ev(1'b0, origin + 49, 16'd1001);
      run_until(origin + 30);
      en = 1'b0;
      run_until(origin + 73);
      check("drop_en_running", {31'd0, running}, 32'd0);
      check("drop_en_clk", {31'd0, clk_out}, 32'd0);
      run_until(origin + 80);
      check("drop_en_held_low", {31'd0, clk_out}, 32'd0);

      // Restart, then reset in the middle of the second high phase
      o2 = cyc;
      en = 1'b1;
      push_ev(1'b1, o2 + 25, 16'd0);
      push_ev(1'b0, o2 + 49, 16'd1002);
      push_ev(1'b1, o2 + 73, 16'd0);
      tick();
      check("restart_running", {31'd0, running}, 32'd1);
      run_until(o2 + 80);
      check("pre_reset_clk_high", {31'd0, clk_out}, 32'd1);
      rst = 1'b0;
      tick();
      check("midhigh_rst_clk", {31'd0, clk_out}, 32'd0);
      check("midhigh_rst_running", {31'd0, running}, 32'd0);
      check("midhigh_rst_count", {16'd0, cycle_count}, 32'd0);
      check("midhigh_rst_no_fall", {31'd0, fall_stb}, 32'd0);
      rst = 1'b1;
      en  = 1'b0;
      repeat (3) tick();
      check("post_rst_idle", {31'd0, running}, 32'd0);

      // cycle_count wrap: preload 0xFFFE, then two falls give 0xFFFF and 0x0000
      o3 = cyc;
      en = 1'b1;
      force dut.cycle_count_r = 16'hFFFE;
      tick();
      release dut.cycle_count_r;
      push_cycles(o3, 2, 16'hFFFE);
      run_until(o3 + 1 + 4 * HP);
      check("wrap_count", {16'd0, cycle_count}, 32'd0);
      en = 1'b0;
      run_until(o3 + 1 + 5 * HP);
      check("wrap_stop_running", {31'd0, running}, 32'd0);

`ifdef CLKGEN_STEP_EN
      // Single step from STOP: exactly one full cycle, then back to STOP
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      origin = cyc;
      step   = 1'b1;
      push_ev(1'b1, origin + 25, 16'd0);
      push_ev(1'b0, origin + 49, 16'd1);
      tick();
      check("step_running", {31'd0, running}, 32'd1);
      run_until(origin + 10);
      step = 1'b0;
      run_until(origin + 73);
      check("step_back_to_stop", {31'd0, running}, 32'd0);
      check("step_count", {16'd0, cycle_count}, 32'd1);
      run_until(origin + 100);
      check("step_stays_low", {31'd0, clk_out}, 32'd0);
`endif

      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
